// File: rtl/life_pkg.sv
// Shared key indices, per-key FSM state encoding and counter width default.
// The REPEAT state exists only when LIFE_KEY_AUTOREPEAT_EN is defined.
package life_pkg;

  localparam int unsigned KEY_DOWN      = 0;
  localparam int unsigned KEY_UP        = 1;
  localparam int unsigned KEY_LEFT      = 2;
  localparam int unsigned KEY_RIGHT     = 3;
  localparam int unsigned NUM_KEYS      = 4;
  localparam int unsigned CNT_W_DEFAULT = 20;

`ifdef LIFE_KEY_AUTOREPEAT_EN
  typedef enum logic [2:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait,
    StRepeat
  } key_state_e;
`else
  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } key_state_e;
`endif

endpackage

// File: rtl/life_key_debounce_if.sv
// Raw button inputs and debounced key levels for the cursor stage.
// master drives the buttons (board side), slave is the debouncer.
interface life_key_debounce_if;

  logic [3:0] btn_raw;
  logic       key_down;
  logic       key_up;
  logic       key_left;
  logic       key_right;

  modport master (
    output btn_raw,
    input  key_down,
    input  key_up,
    input  key_left,
    input  key_right
  );

  modport slave (
    input  btn_raw,
    output key_down,
    output key_up,
    output key_left,
    output key_right
  );

endinterface

// File: rtl/life_key_filter.sv
// One key: 2-flop synchronizer, debounce FSM and counter, registered level output.
// LIFE_KEY_AUTOREPEAT_EN adds a HELD timer that drops the output for one cycle periodically.
module life_key_filter
  import life_pkg::*;
#(
  parameter int unsigned      CNT_W           = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 20'd500000
`ifdef LIFE_KEY_AUTOREPEAT_EN
  ,
  parameter logic [CNT_W-1:0] REPEAT_DELAY    = 20'd1000000,
  parameter logic [CNT_W-1:0] REPEAT_PERIOD   = 20'd250000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_key
);

  logic [1:0]       r_sync;
  key_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_key;
  logic             w_synced;
`ifdef LIFE_KEY_AUTOREPEAT_EN
  logic [CNT_W-1:0] r_rcnt;
  logic             r_first;
`endif

  assign w_synced = r_sync[1];
  assign o_key    = r_key;

  // The output is registered from the current state, so it trails the state by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_state <= StIdle;
      r_cnt   <= '0;
      r_key   <= 1'b0;
`ifdef LIFE_KEY_AUTOREPEAT_EN
      r_rcnt  <= '0;
      r_first <= 1'b1;
`endif
    end else begin
      r_sync <= {r_sync[0], i_raw};
      r_key  <= (r_state == StHeld) || (r_state == StReleaseWait);
      case (r_state)
        StIdle: begin
          if (w_synced) begin
            r_state <= StPressWait;
            r_cnt   <= '0;
          end
        end
        StPressWait: begin
          if (!w_synced) begin
            r_state <= StIdle;
            r_cnt   <= '0;
          end else if (r_cnt == DEBOUNCE_CYCLES - 1'b1) begin
            r_state <= StHeld;
            r_cnt   <= '0;
`ifdef LIFE_KEY_AUTOREPEAT_EN
            r_rcnt  <= '0;
            r_first <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StHeld: begin
          if (!w_synced) begin
            r_state <= StReleaseWait;
            r_cnt   <= '0;
`ifdef LIFE_KEY_AUTOREPEAT_EN
          end else if (r_rcnt == (r_first ? REPEAT_DELAY : REPEAT_PERIOD) - 1'b1) begin
            r_state <= StRepeat;
            r_rcnt  <= '0;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
`endif
          end
        end
        StReleaseWait: begin
          if (w_synced) begin
            // Bounce back to HELD restarts the repeat delay from scratch.
            r_state <= StHeld;
            r_cnt   <= '0;
`ifdef LIFE_KEY_AUTOREPEAT_EN
            r_rcnt  <= '0;
            r_first <= 1'b1;
`endif
          end else if (r_cnt == DEBOUNCE_CYCLES - 1'b1) begin
            r_state <= StIdle;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef LIFE_KEY_AUTOREPEAT_EN
        StRepeat: begin
          r_cnt  <= '0;
          r_rcnt <= '0;
          if (!w_synced) begin
            r_state <= StReleaseWait;
          end else begin
            r_state <= StHeld;
            r_first <= 1'b0;
          end
        end
`endif
        default: begin
          r_state <= StIdle;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/life_key_debounce.sv
// Four independent debounced cursor keys (down, up, left, right).
// Define LIFE_KEY_AUTOREPEAT_EN to enable the held-key auto-repeat pulses.
module life_key_debounce
  import life_pkg::*;
#(
  parameter int unsigned      CNT_W           = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 20'd500000
`ifdef LIFE_KEY_AUTOREPEAT_EN
  ,
  parameter logic [CNT_W-1:0] REPEAT_DELAY    = 20'd1000000,
  parameter logic [CNT_W-1:0] REPEAT_PERIOD   = 20'd250000
`endif
) (
  input logic                clk,
  input logic                rst_n,
  life_key_debounce_if.slave key_if
);

  logic [NUM_KEYS-1:0] w_keys;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    life_key_filter #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef LIFE_KEY_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_filter (
      .clk  (clk),
      .rst_n(rst_n),
      .i_raw(key_if.btn_raw[g]),
      .o_key(w_keys[g])
    );
  end

  assign key_if.key_down  = w_keys[KEY_DOWN];
  assign key_if.key_up    = w_keys[KEY_UP];
  assign key_if.key_left  = w_keys[KEY_LEFT];
  assign key_if.key_right = w_keys[KEY_RIGHT];

endmodule

// File: tb/tb_life_key_debounce.sv
// Bench for life_key_debounce: run-length reference model checked every cycle,
// plus directed scenarios with literal expectations (also built with LIFE_KEY_AUTOREPEAT_EN).
module tb_life_key_debounce;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  life_key_debounce_if u_if ();

  life_key_debounce #(
    .CNT_W          (20),
    .DEBOUNCE_CYCLES(20'd4)
`ifdef LIFE_KEY_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY   (20'd10),
    .REPEAT_PERIOD  (20'd5)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key_if(u_if)
  );

  always #5 clk = ~clk;

  logic [3:0] w_keys;
  assign w_keys = {u_if.key_right, u_if.key_left, u_if.key_up, u_if.key_down};

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  // Reference model: a level flips once D+1 consecutive synced samples disagree with it;
  // synced = raw two edges late, visible output one edge after the level.
  logic [3:0] m_s1, m_s2, m_lvl, m_pulse, m_out;
  int         m_run[4];
  int         m_t[4];

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0; m_out = '0;
        for (int i = 0; i < 4; i++) begin
          m_run[i] = 0;
          m_t[i]   = -1;
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          m_out[i]   = m_lvl[i] & ~m_pulse[i];
          m_pulse[i] = 1'b0;
          if (m_s2[i] != m_lvl[i]) begin
            m_run[i]++;
            m_t[i] = -1;
            if (m_run[i] == D + 1) begin
              m_lvl[i] = m_s2[i];
              m_run[i] = 0;
              m_t[i]   = 0;
            end
          end else begin
            m_run[i] = 0;
            if (m_lvl[i]) begin
              m_t[i]++;
`ifdef LIFE_KEY_AUTOREPEAT_EN
              if (m_t[i] == RD || (m_t[i] > RD && (m_t[i] - RD) % (RP + 1) == 0))
                m_pulse[i] = 1'b1;
`endif
            end
          end
        end
        m_s2 = m_s1;
        m_s1 = u_if.btn_raw;
      end
      #1;
      check("model_cycle", w_keys, m_out);
    end
  end

  initial begin
    u_if.btn_raw = 4'b0000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", w_keys, 4'b0000);
    rst_n = 1'b1;

    // Clean press of down at edge 0, release at edge 20.
    @(negedge clk); u_if.btn_raw[0] = 1'b1;
    repeat (7) @(negedge clk); check("down_press_e6", w_keys, 4'b0000);
    @(negedge clk);            check("down_press_e7", w_keys, 4'b0001);
    repeat (12) @(negedge clk); u_if.btn_raw[0] = 1'b0;
    repeat (7) @(negedge clk); check("down_rel_e26", w_keys, 4'b0001);
    @(negedge clk);            check("down_rel_e27", w_keys, 4'b0000);
    repeat (4) @(negedge clk);

    // Left bounces 1,0,1,0 then settles high on the fifth cycle.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      u_if.btn_raw[2] = (k % 2 == 0);
    end
    repeat (7) @(negedge clk); check("left_bounce_e6", w_keys, 4'b0000);
    @(negedge clk);            check("left_bounce_e7", w_keys, 4'b0100);
    u_if.btn_raw[2] = 1'b0;
    repeat (10) @(negedge clk);
    check("left_released", w_keys, 4'b0000);

    // All four rise together.
    u_if.btn_raw = 4'b1111;
    repeat (7) @(negedge clk); check("all_e6", w_keys, 4'b0000);
    @(negedge clk);            check("all_e7", w_keys, 4'b1111);
    u_if.btn_raw = 4'b0000;
    repeat (10) @(negedge clk);
    check("all_released", w_keys, 4'b0000);

    // Reset while up is HELD, button kept down through reset.
    u_if.btn_raw[1] = 1'b1;
    repeat (8) @(negedge clk); check("up_held", w_keys, 4'b0010);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 check("up_async_reset", w_keys, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk); check("up_after_rst_e6", w_keys, 4'b0000);
    @(negedge clk);            check("up_after_rst_e7", w_keys, 4'b0010);
    u_if.btn_raw[1] = 1'b0;
    repeat (10) @(negedge clk);

    // Right held 40 cycles: repeat pulses at edges 17 and 23 when enabled.
    u_if.btn_raw[3] = 1'b1;
    repeat (17) @(negedge clk); check("right_e16", w_keys, 4'b1000);
`ifdef LIFE_KEY_AUTOREPEAT_EN
    @(negedge clk);             check("right_e17_pulse", w_keys, 4'b0000);
    @(negedge clk);             check("right_e18", w_keys, 4'b1000);
    repeat (5) @(negedge clk);  check("right_e23_pulse", w_keys, 4'b0000);
`else
    @(negedge clk);             check("right_e17_steady", w_keys, 4'b1000);
    @(negedge clk);             check("right_e18", w_keys, 4'b1000);
    repeat (5) @(negedge clk);  check("right_e23_steady", w_keys, 4'b1000);
`endif
    repeat (16) @(negedge clk);
    u_if.btn_raw[3] = 1'b0;
    repeat (12) @(negedge clk);
    check("right_released", w_keys, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/life_key_debounce.md
LIFE_KEY_DEBOUNCE -- requirements
Module: life_key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20'd500000: number of consecutive stable synchronized samples required to accept a level change.
REQ-002 Parameter CNT_W, default 20: width of the debounce and repeat counters; every timing parameter SHALL fit in CNT_W bits.
REQ-003 Parameter REPEAT_DELAY, default 20'd1000000: HELD cycles before the first auto-repeat pulse; used only with LIFE_KEY_AUTOREPEAT_EN.
REQ-004 Parameter REPEAT_PERIOD, default 20'd250000: HELD cycles between later auto-repeat pulses; used only with LIFE_KEY_AUTOREPEAT_EN.
REQ-005 clk  input  1  single clock; all state on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 btn_raw  input  4  raw asynchronous buttons, active-high; bit 0 down, 1 up, 2 left, 3 right.
REQ-008 key_down, key_up, key_left, key_right  output  1 each  debounced active-high levels for the cursor stage, registered.

Function
REQ-009 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-010 Each key SHALL run an independent FSM: IDLE (out 0), PRESS_WAIT (out 0), HELD (out 1), RELEASE_WAIT (out 1).
REQ-011 IDLE->PRESS_WAIT when the synced input is 1, with the counter cleared; HELD->RELEASE_WAIT when the synced input is 0, with the counter cleared.
REQ-012 In a WAIT state with the synced input at the target level, the counter SHALL increment; at count == DEBOUNCE_CYCLES-1 the FSM SHALL enter HELD (press) or IDLE (release).
REQ-013 In a WAIT state with the synced input back at the old level (bounce), the FSM SHALL return to the prior stable state, clear the counter, and leave the output unchanged.
REQ-014 Latency: an output SHALL change exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples a stable new raw level.
REQ-015 Keys SHALL be fully independent; simultaneous presses and releases on any subset SHALL each be processed with identical latency.
REQ-016 The counter SHALL never wrap; it is cleared on every state entry.
REQ-017 Outputs SHALL be glitch-free register outputs; one level change per accepted transition.

Reset
REQ-018 When rst_n is low, all synchronizer flops, counters and outputs SHALL be 0 and every FSM SHALL be in IDLE, asynchronously, including mid-PRESS_WAIT or mid-HELD.
REQ-019 After rst_n deasserts, a button already held SHALL be reported only after full debounce (REQ-014).

Configuration
REQ-020 With macro LIFE_KEY_AUTOREPEAT_EN defined, HELD SHALL count cycles; at REPEAT_DELAY-1 (first) or REPEAT_PERIOD-1 (subsequent), the FSM SHALL enter a REPEAT state.
REQ-021 In REPEAT, the output SHALL be 0 for exactly one cycle, then the FSM SHALL return to HELD. This produces one extra release edge, and therefore one cursor step, downstream.
REQ-022 A synced 0 seen in REPEAT SHALL go to RELEASE_WAIT.
REQ-023 Without LIFE_KEY_AUTOREPEAT_EN, the REPEAT state, the repeat counter and the REPEAT_* parameter use SHALL be absent; HELD exits only via REQ-011.

Structure
REQ-024 Shared package life_pkg SHALL hold: the key index constants (KEY_DOWN=0, KEY_UP=1, KEY_LEFT=2, KEY_RIGHT=3), the FSM state encoding and the default CNT_W.
REQ-025 Per-key synchronizer, FSM and counter SHALL live in sub-module life_key_filter, instantiated 4 times by life_key_debounce.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-026 Clean press of btn_raw[0] at edge 0 -> key_down=1 at edge 7; release at edge 20 -> key_down=0 at edge 27.
REQ-027 btn_raw[2] bouncing 1,0,1,0 on alternate cycles, then stable 1 -> key_left stays 0 until 7 edges after the last 0->1, then 1.
REQ-028 All 4 raw bits rise on the same edge -> all 4 outputs rise on the same edge, 7 edges later.
REQ-029 rst_n pulled low while key_up=1 in HELD -> key_up=0 immediately; button still held after release of rst_n -> key_up=1 7 edges later.
REQ-030 Macro defined, btn_raw[3] held 40 cycles -> key_right low pulses (1 cycle each) 10 cycles after HELD entry, then every 6 cycles (5 HELD + 1 REPEAT); macro undefined -> no pulses.
